memory_port_arbiter: RTL and testbench

//  Shares the single memory port between instruction fetch and the load/store path.
//  The load/store path is driven by the control unit's mem-write-enable and load/store-type decode.

---
 rtl/memory_port_arbiter_pkg.sv | 15 +
 rtl/memory_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and transaction owners.
package memory_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_STATE_IDLE      = 2'd0,
        ARB_STATE_ISSUE     = 2'd1,
        ARB_STATE_WAIT_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_FETCH = 1'b0,
        ARB_OWNER_DATA  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Optional MEMORY_ARBITER_STARVATION_GUARD_EN lets a waiting fetch win after MAX_DATA_BURST data grants.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset_N,
    input  logic                    i_Flush,
    input  logic                    i_Fetch_Req,
    input  logic [ADDR_WIDTH-1:0]   i_Fetch_Addr,
    output logic                    o_Fetch_Grant,
    output logic                    o_Fetch_Valid,
    output logic [DATA_WIDTH-1:0]   o_Fetch_Data,
    input  logic                    i_Data_Req,
    input  logic                    i_Data_Write,
    input  logic [ADDR_WIDTH-1:0]   i_Data_Addr,
    input  logic [DATA_WIDTH-1:0]   i_Data_Wdata,
    input  logic [DATA_WIDTH/8-1:0] i_Data_Strobe,
    output logic                    o_Data_Grant,
    output logic                    o_Data_Valid,
    output logic [DATA_WIDTH-1:0]   o_Data_Rdata,
    output logic                    o_Stall,
    output logic                    o_Mem_Req,
    output logic                    o_Mem_Write,
    output logic [ADDR_WIDTH-1:0]   o_Mem_Addr,
    output logic [DATA_WIDTH-1:0]   o_Mem_Wdata,
    output logic [DATA_WIDTH/8-1:0] o_Mem_Strobe,
    input  logic                    i_Mem_Ready,
    input  logic                    i_Mem_Resp_Valid,
    input  logic [DATA_WIDTH-1:0]   i_Mem_Rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (MAX_DATA_BURST < 1) begin : g_bad_burst
        $error("MAX_DATA_BURST must be at least 1");
    end

    arb_state_e              state, state_next;
    arb_owner_e              owner, owner_next;
    logic                    drop, drop_next;
    logic                    mem_write_q, mem_write_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_next;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_next;
    logic [STRB_WIDTH-1:0]   mem_strobe_q, mem_strobe_next;
    logic                    fetch_valid_q, fetch_valid_next;
    logic                    data_valid_q, data_valid_next;
    logic [DATA_WIDTH-1:0]   fetch_data_q, fetch_data_next;
    logic [DATA_WIDTH-1:0]   data_rdata_q, data_rdata_next;
    logic                    fetch_grant, data_grant;
    logic                    guard_fetch;

`ifdef MEMORY_ARBITER_STARVATION_GUARD_EN
    localparam int BURST_W = $clog2(MAX_DATA_BURST + 1);
    logic [BURST_W-1:0] burst_cnt;

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            burst_cnt <= '0;
        end else if (fetch_grant) begin
            burst_cnt <= '0;
        end else if (data_grant && burst_cnt != BURST_W'(MAX_DATA_BURST)) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
        end
    end

    assign guard_fetch = (burst_cnt == BURST_W'(MAX_DATA_BURST));
`else
    assign guard_fetch = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next       = state;
        owner_next       = owner;
        drop_next        = drop;
        mem_write_next   = mem_write_q;
        mem_addr_next    = mem_addr_q;
        mem_wdata_next   = mem_wdata_q;
        mem_strobe_next  = mem_strobe_q;
        fetch_valid_next = 1'b0;
        data_valid_next  = 1'b0;
        fetch_data_next  = fetch_data_q;
        data_rdata_next  = data_rdata_q;
        fetch_grant      = 1'b0;
        data_grant       = 1'b0;

        unique case (state)
            ARB_STATE_IDLE: begin
                drop_next = 1'b0;
                if (i_Fetch_Req && (!i_Data_Req || guard_fetch)) begin
                    owner_next      = ARB_OWNER_FETCH;
                    mem_write_next  = 1'b0;
                    mem_addr_next   = i_Fetch_Addr;
                    mem_wdata_next  = '0;
                    mem_strobe_next = '1;
                    state_next      = ARB_STATE_ISSUE;
                end else if (i_Data_Req) begin
                    owner_next      = ARB_OWNER_DATA;
                    mem_write_next  = i_Data_Write;
                    mem_addr_next   = i_Data_Addr;
                    mem_wdata_next  = i_Data_Wdata;
                    mem_strobe_next = i_Data_Strobe;
                    state_next      = ARB_STATE_ISSUE;
                end
            end
            ARB_STATE_ISSUE: begin
                if (i_Flush && owner == ARB_OWNER_FETCH) drop_next = 1'b1;
                if (i_Mem_Ready) begin
                    fetch_grant = (owner == ARB_OWNER_FETCH);
                    data_grant  = (owner == ARB_OWNER_DATA);
                    state_next  = ARB_STATE_WAIT_RESP;
                end
            end
            ARB_STATE_WAIT_RESP: begin
                if (i_Flush && owner == ARB_OWNER_FETCH) drop_next = 1'b1;
                if (i_Mem_Resp_Valid) begin
                    state_next = ARB_STATE_IDLE;
                    if (owner == ARB_OWNER_DATA) begin
                        data_valid_next = 1'b1;
                        data_rdata_next = i_Mem_Rdata;
                    end else if (!drop && !i_Flush) begin
                        // A flush landing with the response still kills the fetch.
                        fetch_valid_next = 1'b1;
                        fetch_data_next  = i_Mem_Rdata;
                    end
                end
            end
            default: state_next = ARB_STATE_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!i_Reset_N) begin
            state         <= ARB_STATE_IDLE;
            owner         <= ARB_OWNER_FETCH;
            drop          <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_strobe_q  <= '0;
            fetch_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
            fetch_data_q  <= '0;
            data_rdata_q  <= '0;
        end else begin
            state         <= state_next;
            owner         <= owner_next;
            drop          <= drop_next;
            mem_write_q   <= mem_write_next;
            mem_addr_q    <= mem_addr_next;
            mem_wdata_q   <= mem_wdata_next;
            mem_strobe_q  <= mem_strobe_next;
            fetch_valid_q <= fetch_valid_next;
            data_valid_q  <= data_valid_next;
            fetch_data_q  <= fetch_data_next;
            data_rdata_q  <= data_rdata_next;
        end
    end

    assign o_Fetch_Grant = fetch_grant;
    assign o_Data_Grant  = data_grant;
    assign o_Fetch_Valid = fetch_valid_q;
    assign o_Fetch_Data  = fetch_data_q;
    assign o_Data_Valid  = data_valid_q;
    assign o_Data_Rdata  = data_rdata_q;
    assign o_Mem_Req     = (state == ARB_STATE_ISSUE);
    assign o_Mem_Write   = mem_write_q;
    assign o_Mem_Addr    = mem_addr_q;
    assign o_Mem_Wdata   = mem_wdata_q;
    assign o_Mem_Strobe  = mem_strobe_q;
    assign o_Stall       = (state == ARB_STATE_IDLE && i_Data_Req) ||
                           (owner == ARB_OWNER_DATA && state != ARB_STATE_IDLE);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: stimulus queues expected grant/valid events, a monitor pops them.
module tb_memory_port_arbiter;

    localparam logic [1:0] EV_FG = 2'd0;
    localparam logic [1:0] EV_FV = 2'd1;
    localparam logic [1:0] EV_DG = 2'd2;
    localparam logic [1:0] EV_DV = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic        chk;
        logic [31:0] data;
    } ev_t;

    logic        clk, rst_n, flush;
    logic        fetch_req, fetch_grant, fetch_valid;
    logic [31:0] fetch_addr, fetch_data;
    logic        data_req, data_write, data_grant, data_valid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_strobe;
    logic        stall, mem_req, mem_write, mem_ready, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_strobe;

    ev_t exp_q[$];
    int  n_pass = 0;
    int  n_total = 0;
    int  fgrant_seen = 0;
    int  fvalid_seen = 0;
    int  dgrant_seen = 0;
    int  resp_delay = 2;

    memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_BURST(4)) dut (
        .i_Clock(clk), .i_Reset_N(rst_n), .i_Flush(flush),
        .i_Fetch_Req(fetch_req), .i_Fetch_Addr(fetch_addr),
        .o_Fetch_Grant(fetch_grant), .o_Fetch_Valid(fetch_valid), .o_Fetch_Data(fetch_data),
        .i_Data_Req(data_req), .i_Data_Write(data_write), .i_Data_Addr(data_addr),
        .i_Data_Wdata(data_wdata), .i_Data_Strobe(data_strobe),
        .o_Data_Grant(data_grant), .o_Data_Valid(data_valid), .o_Data_Rdata(data_rdata),
        .o_Stall(stall), .o_Mem_Req(mem_req), .o_Mem_Write(mem_write), .o_Mem_Addr(mem_addr),
        .o_Mem_Wdata(mem_wdata), .o_Mem_Strobe(mem_strobe), .i_Mem_Ready(mem_ready),
        .i_Mem_Resp_Valid(mem_resp_valid), .i_Mem_Rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic chk, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.chk  = chk;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sb_match(input logic [1:0] kind, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", {30'd0, kind}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("sb_event_kind", {30'd0, kind}, {30'd0, e.kind});
            if (e.chk) check("sb_resp_data", data, e.data);
        end
    endtask

    // Memory contents seen by the responder.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (fetch_grant) begin fgrant_seen++; sb_match(EV_FG, 32'h0); end
            if (fetch_valid) begin fvalid_seen++; sb_match(EV_FV, fetch_data); end
            if (data_grant)  begin dgrant_seen++; sb_match(EV_DG, 32'h0); end
            if (data_valid)  sb_match(EV_DV, data_rdata);
        end
    end

    initial begin
        logic [31:0] resp_addr;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req && mem_ready) begin
                resp_addr = mem_addr;
                repeat (resp_delay) @(posedge clk);
                #1;
                mem_resp_valid = 1'b1;
                mem_rdata      = mem_model(resp_addr);
                @(posedge clk);
                #1 mem_resp_valid = 1'b0;
            end
        end
    end

    task automatic hold_fetch(input logic [31:0] addr);
        int n = 0;
        @(posedge clk);
        #1;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        do begin @(negedge clk); n++; end while (!fetch_grant && n < 60);
        check("fetch_grant_arrives", {31'd0, fetch_grant}, 32'd1);
        @(posedge clk);
        #1 fetch_req = 1'b0;
    endtask

    task automatic hold_data(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                             input logic [3:0] strb);
        int n = 0;
        @(posedge clk);
        #1;
        data_req    = 1'b1;
        data_addr   = addr;
        data_write  = wr;
        data_wdata  = wd;
        data_strobe = strb;
        do begin @(negedge clk); n++; end while (!data_grant && n < 60);
        check("data_grant_arrives", {31'd0, data_grant}, 32'd1);
        @(posedge clk);
        #1 data_req = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        check("sb_drained", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  cnt;
        int  fg0;
        int  nv;
        logic stall_ok;

        rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_write = 1'b0; data_addr = '0; data_wdata = '0; data_strobe = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_fetch_data", fetch_data, 32'd0);
        check("rst_mem_strobe", {28'd0, mem_strobe}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single fetch: grant, then instruction word 0x13 two cycles after acceptance.
        push_ev(EV_FG, 1'b0, 32'h0);
        push_ev(EV_FV, 1'b1, 32'h0000_0013);
        fork
            hold_fetch(32'h0);
            begin
                @(posedge clk); #2;
                repeat (2) @(negedge clk);
                check("fetch_issue_req", {31'd0, mem_req}, 32'd1);
                check("fetch_strobe_ones", {28'd0, mem_strobe}, 32'hF);
                check("fetch_not_write", {31'd0, mem_write}, 32'd0);
            end
        join
        wait_drain();
        check("fetch_data_0x13", fetch_data, 32'h0000_0013);

        // Fetch and load together: load first, stall until its valid, then fetch.
        push_ev(EV_DG, 1'b0, 32'h0);
        push_ev(EV_DV, 1'b1, 32'h5A5A_0200);
        push_ev(EV_FG, 1'b0, 32'h0);
        push_ev(EV_FV, 1'b1, 32'h5A5A_0008);
        fork
            hold_fetch(32'h8);
            begin
                hold_data(32'h200, 1'b0, 32'h0, 4'hF);
                n = 0;
                stall_ok = 1'b1;
                do begin
                    @(negedge clk); n++;
                    if (!data_valid) stall_ok = stall_ok & stall;
                end while (!data_valid && n < 20);
                check("load_valid_arrives", {31'd0, data_valid}, 32'd1);
                check("stall_held_until_valid", {31'd0, stall_ok}, 32'd1);
                check("stall_falls_at_valid", {31'd0, stall}, 32'd0);
            end
            begin
                @(posedge clk); #2;
                @(negedge clk);
                check("stall_idle_data_req", {31'd0, stall}, 32'd1);
            end
        join
        wait_drain();

        // Store with memory back-pressure: fields stay stable while o_Mem_Req waits.
        mem_ready = 1'b0;
        push_ev(EV_DG, 1'b0, 32'h0);
        push_ev(EV_DV, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        data_req = 1'b1; data_write = 1'b1; data_addr = 32'h100;
        data_wdata = 32'hAABB_CCDD; data_strobe = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        check("store_req", {31'd0, mem_req}, 32'd1);
        check("store_write", {31'd0, mem_write}, 32'd1);
        check("store_addr", mem_addr, 32'h100);
        check("store_wdata", mem_wdata, 32'hAABB_CCDD);
        check("store_strobe", {28'd0, mem_strobe}, 32'h2);
        @(negedge clk);
        check("store_req_held", {31'd0, mem_req}, 32'd1);
        check("store_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1 mem_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 data_req = 1'b0;
        data_write = 1'b0;
        wait_drain();

        // Flushed fetch: no valid, held fetch data; the next fetch completes.
        push_ev(EV_FG, 1'b0, 32'h0);
        hold_fetch(32'hC);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        nv = fvalid_seen;
        repeat (6) @(negedge clk);
        check("flushed_fetch_no_valid", fvalid_seen - nv, 32'd0);
        check("fetch_data_held", fetch_data, 32'h5A5A_0008);
        push_ev(EV_FG, 1'b0, 32'h0);
        push_ev(EV_FV, 1'b1, 32'h5A5A_0010);
        hold_fetch(32'h10);
        wait_drain();

        // Continuous loads with a fetch waiting.
`ifdef MEMORY_ARBITER_STARVATION_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            push_ev(EV_DG, 1'b0, 32'h0);
            push_ev(EV_DV, 1'b1, 32'h5A5A_0300);
        end
        push_ev(EV_FG, 1'b0, 32'h0);
        push_ev(EV_FV, 1'b1, 32'h5A5A_0014);
        for (int i = 0; i < 2; i++) begin
            push_ev(EV_DG, 1'b0, 32'h0);
            push_ev(EV_DV, 1'b1, 32'h5A5A_0300);
        end
`else
        for (int i = 0; i < 6; i++) begin
            push_ev(EV_DG, 1'b0, 32'h0);
            push_ev(EV_DV, 1'b1, 32'h5A5A_0300);
        end
        push_ev(EV_FG, 1'b0, 32'h0);
        push_ev(EV_FV, 1'b1, 32'h5A5A_0014);
`endif
        fg0 = fgrant_seen;
        fork
            hold_fetch(32'h14);
            begin
                @(posedge clk);
                #1;
                data_req = 1'b1; data_write = 1'b0; data_addr = 32'h300; data_strobe = 4'hF;
                cnt = 0;
                n = 0;
                do begin
                    @(negedge clk); n++;
                    if (data_grant) cnt++;
                end while (cnt < 6 && n < 200);
                check("burst_data_grants", cnt, 32'd6);
`ifdef MEMORY_ARBITER_STARVATION_GUARD_EN
                check("burst_fetch_interleaved", fgrant_seen - fg0, 32'd1);
`else
                check("burst_fetch_starved", fgrant_seen - fg0, 32'd0);
`endif
                @(posedge clk);
                #1 data_req = 1'b0;
            end
        join
        wait_drain();

        // Reset during WAIT_RESP, then a late response that must be ignored.
        resp_delay = 6;
        push_ev(EV_FG, 1'b0, 32'h0);
        hold_fetch(32'h18);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_fetch_data", fetch_data, 32'd0);
        check("mid_rst_data_rdata", data_rdata, 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nv = fvalid_seen;
        repeat (10) @(negedge clk);
        check("late_resp_no_valid", fvalid_seen - nv, 32'd0);
        check("late_resp_data_clear", fetch_data, 32'd0);
        resp_delay = 2;
        push_ev(EV_FG, 1'b0, 32'h0);
        push_ev(EV_FV, 1'b1, 32'h5A5A_001C);
        hold_fetch(32'h1C);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
